// File: rtl/olivia_mc_sequencer_if.sv
// Memory-side bus of the Olivia multi-cycle sequencer: instruction fetch
// channel and data channel, each a request valid/ready pair plus a response
// valid. The sequencer is the master; instruction/data memories are slaves.
interface olivia_mc_sequencer_if #(
    parameter int XLEN = 64
);
    // Instruction fetch channel
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    // Data channel (load data itself travels on the datapath, not here)
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_we;
    logic            dmem_rsp_valid;

    modport master (
        output imem_req_valid, imem_addr, dmem_req_valid, dmem_we,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               dmem_req_ready, dmem_rsp_valid
    );

    modport slave (
        input  imem_req_valid, imem_addr, dmem_req_valid, dmem_we,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               dmem_req_ready, dmem_rsp_valid
    );
endinterface

// File: rtl/olivia_mc_sequencer.sv
// Olivia multi-cycle sequencer: owns PC and IR and walks each LEGv8
// instruction through FETCH_REQ / FETCH_WAIT / DECODE / EXECUTE /
// MEM_REQ / MEM_WAIT / WRITEBACK, with a sticky ERROR state on timeout.
// Decode flags come from the external Control_Unit driven by o_instr.
// Optional feature: define OLIVIA_PERF_CNT_EN to build the retire/stall
// performance counters; otherwise both counter outputs are constant 0.
module olivia_mc_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    olivia_mc_sequencer_if.master bus,
    output logic [31:0]          o_instr,
    output logic [XLEN-1:0]      o_pc,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_branch,
    input  logic                 i_uncond_branch,
    input  logic                 i_reg_write,
    input  logic                 i_zero_flag,
    input  logic [XLEN-1:0]      i_branch_imm,
    output logic                 o_rf_we,
    output logic                 o_retire,
    output logic                 o_err,
    output logic [CNT_W-1:0]     o_retire_cnt,
    output logic [CNT_W-1:0]     o_stall_cnt
);

    // Timer is never narrower than 8 bits so small TIMEOUT builds keep headroom.
    localparam int TMR_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM_REQ    = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WRITEBACK  = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_target;
    logic [31:0]     r_instr;
    logic            r_imem_req_valid;
    logic            r_dmem_req_valid;
    logic            r_dmem_we;
    logic            r_rf_we;
    logic            r_retire;
    logic            r_err;
    logic [TMR_W-1:0] r_timer;

    logic            w_fetch_acc;
    logic            w_mem_acc;
    logic            w_waiting;
    logic            w_timer_last;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_pc_branch;

    // Handshake completes only while our own valid is up in the matching
    // request state; ready seen at any other time is ignored.
    assign w_fetch_acc = (r_state == S_FETCH_REQ) && r_imem_req_valid && bus.imem_req_ready;
    assign w_mem_acc   = (r_state == S_MEM_REQ)   && r_dmem_req_valid && bus.dmem_req_ready;

    // Cycles that count as stalls and against the timeout. The single
    // post-reset cycle in FETCH_REQ before valid rises is not a wait.
    assign w_waiting = ((r_state == S_FETCH_REQ) && r_imem_req_valid) ||
                       (r_state == S_FETCH_WAIT) ||
                       (r_state == S_MEM_REQ)    ||
                       (r_state == S_MEM_WAIT);

    assign w_timer_last = (r_timer == TMR_LAST);

    // Branch decision and both candidate targets, resolved in EXECUTE.
    assign w_taken     = (i_branch && i_zero_flag) || i_uncond_branch;
    assign w_pc_seq    = r_pc + XLEN'(4);
    assign w_pc_branch = r_pc + (i_branch_imm << 2);

    // Main sequencing FSM with all strobes registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_FETCH_REQ;
            r_pc             <= RESET_PC;
            r_pc_target      <= RESET_PC;
            r_instr          <= '0;
            r_imem_req_valid <= 1'b0;
            r_dmem_req_valid <= 1'b0;
            r_dmem_we        <= 1'b0;
            r_rf_we          <= 1'b0;
            r_retire         <= 1'b0;
            r_err            <= 1'b0;
            r_timer          <= '0;
        end else begin
            // One-cycle strobes fall back to 0 unless set below.
            r_rf_we  <= 1'b0;
            r_retire <= 1'b0;

            case (r_state)
                S_FETCH_REQ: begin
                    if (!r_imem_req_valid) begin
                        // First cycle out of reset: raise the request.
                        r_imem_req_valid <= 1'b1;
                        r_timer          <= '0;
                    end else if (w_fetch_acc) begin
                        r_imem_req_valid <= 1'b0;
                        r_timer          <= '0;
                        r_state          <= S_FETCH_WAIT;
                    end else if (w_timer_last) begin
                        r_imem_req_valid <= 1'b0;
                        r_err            <= 1'b1;
                        r_timer          <= '0;
                        r_state          <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_FETCH_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_instr <= bus.imem_rsp_data;
                        r_timer <= '0;
                        r_state <= S_DECODE;
                    end else if (w_timer_last) begin
                        r_err   <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DECODE: begin
                    // Control_Unit flags settle from the new IR this cycle.
                    r_timer <= '0;
                    r_state <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    // Latch the next PC now so WRITEBACK does not depend on
                    // flags that might move once the next fetch begins.
                    r_pc_target <= w_taken ? w_pc_branch : w_pc_seq;
                    r_timer     <= '0;
                    if (i_mem_read || i_mem_write) begin
                        r_dmem_req_valid <= 1'b1;
                        // Both flags set is treated as a store.
                        r_dmem_we        <= i_mem_write;
                        r_state          <= S_MEM_REQ;
                    end else begin
                        r_rf_we  <= i_reg_write;
                        r_retire <= 1'b1;
                        r_state  <= S_WRITEBACK;
                    end
                end

                S_MEM_REQ: begin
                    if (w_mem_acc) begin
                        r_dmem_req_valid <= 1'b0;
                        r_dmem_we        <= 1'b0;
                        r_timer          <= '0;
                        r_state          <= S_MEM_WAIT;
                    end else if (w_timer_last) begin
                        r_dmem_req_valid <= 1'b0;
                        r_dmem_we        <= 1'b0;
                        r_err            <= 1'b1;
                        r_timer          <= '0;
                        r_state          <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_MEM_WAIT: begin
                    if (bus.dmem_rsp_valid) begin
                        r_rf_we  <= i_reg_write;
                        r_retire <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= S_WRITEBACK;
                    end else if (w_timer_last) begin
                        r_err   <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WRITEBACK: begin
                    // The only place the PC moves.
                    r_pc             <= r_pc_target;
                    r_imem_req_valid <= 1'b1;
                    r_timer          <= '0;
                    r_state          <= S_FETCH_REQ;
                end

                S_ERROR: begin
                    // Sticky until reset; every strobe stays low.
                    r_imem_req_valid <= 1'b0;
                    r_dmem_req_valid <= 1'b0;
                    r_dmem_we        <= 1'b0;
                    r_err            <= 1'b1;
                    r_timer          <= '0;
                end

                default: begin
                    r_imem_req_valid <= 1'b0;
                    r_dmem_req_valid <= 1'b0;
                    r_dmem_we        <= 1'b0;
                    r_err            <= 1'b1;
                    r_timer          <= '0;
                    r_state          <= S_ERROR;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = r_imem_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.dmem_req_valid = r_dmem_req_valid;
    assign bus.dmem_we        = r_dmem_we;

    assign o_instr  = r_instr;
    assign o_pc     = r_pc;
    assign o_rf_we  = r_rf_we;
    assign o_retire = r_retire;
    assign o_err    = r_err;

`ifdef OLIVIA_PERF_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Free-running performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_retire) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if (w_waiting) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_retire_cnt = r_retire_cnt;
    assign o_stall_cnt  = r_stall_cnt;
`else
    assign o_retire_cnt = '0;
    assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_olivia_mc_sequencer.sv
// Bench for olivia_mc_sequencer: plays the memories and the Control_Unit,
// drives directed and randomized instruction streams with random memory
// latencies, and compares against a transaction-level reference model.
module tb_olivia_mc_sequencer;

    localparam int XLEN = 64;
    localparam int T    = 6;   // TIMEOUT used for this build
    localparam int CW   = 32;

    // Instruction classes carried in instr[31:29]
    localparam int C_ALU  = 0;
    localparam int C_LDUR = 1;
    localparam int C_STUR = 2;
    localparam int C_CBZ  = 3;
    localparam int C_B    = 4;
    localparam int C_BOTH = 5;
    localparam int C_NOP  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    olivia_mc_sequencer_if #(.XLEN(XLEN)) bus ();

    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            mem_read, mem_write, branch, uncond_branch, reg_write, zero_flag;
    logic [XLEN-1:0] branch_imm;
    logic            rf_we, retire, err;
    logic [CW-1:0]   retire_cnt, stall_cnt;

    olivia_mc_sequencer #(
        .XLEN(XLEN), .RESET_PC('0), .TIMEOUT(T), .CNT_W(CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_instr        (instr),
        .o_pc           (pc),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_branch       (branch),
        .i_uncond_branch(uncond_branch),
        .i_reg_write    (reg_write),
        .i_zero_flag    (zero_flag),
        .i_branch_imm   (branch_imm),
        .o_rf_we        (rf_we),
        .o_retire       (retire),
        .o_err          (err),
        .o_retire_cnt   (retire_cnt),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in Control_Unit decoding the IR.
    always_comb begin
        mem_read      = (instr[31:29] == 3'(C_LDUR)) || (instr[31:29] == 3'(C_BOTH));
        mem_write     = (instr[31:29] == 3'(C_STUR)) || (instr[31:29] == 3'(C_BOTH));
        branch        = (instr[31:29] == 3'(C_CBZ));
        uncond_branch = (instr[31:29] == 3'(C_B));
        reg_write     = (instr[31:29] == 3'(C_ALU)) || (instr[31:29] == 3'(C_LDUR));
        zero_flag     = instr[28];
        branch_imm    = {{(XLEN-16){instr[15]}}, instr[15:0]};
    end

    int total = 0;
    int bad   = 0;
    int retire_seen = 0;
    int model_retired_all = 0;
    logic [63:0] m_pc;
    longint m_cnt_ret;
    longint m_cnt_stall;

    always @(negedge clk) if (retire === 1'b1) retire_seen++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int cls, input bit zf, input int imm);
        logic [31:0] w;
        logic [15:0] filler;
        w = '0;
        filler = 16'($urandom);
        w[31:29] = 3'(cls);
        w[28]    = zf;
        w[27:16] = filler[11:0];
        w[15:0]  = 16'(imm);
        return w;
    endfunction

    // Reference: next PC from the instruction word alone.
    function automatic logic [63:0] model_next_pc(input logic [63:0] cur, input logic [31:0] iw);
        int     cls;
        bit     taken;
        longint off;
        cls   = int'(iw[31:29]);
        taken = (cls == C_CBZ && iw[28]) || (cls == C_B);
        off   = longint'($signed(iw[15:0])) * 4;
        return taken ? cur + 64'(off) : cur + 64'd4;
    endfunction

    task automatic chk_counters();
`ifdef OLIVIA_PERF_CNT_EN
        chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt_ret));
        chk("stall_cnt",  64'(stall_cnt),  64'(m_cnt_stall));
`else
        chk("retire_cnt", 64'(retire_cnt), 64'd0);
        chk("stall_cnt",  64'(stall_cnt),  64'd0);
`endif
    endtask

    task automatic quiet_bus();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
    endtask

    // Assert reset at a negedge, check the reset image, release, feed
    // stale responses, and confirm the fetch request rises next cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        quiet_bus();
        #1;
        chk("rst_pc", pc, 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_ivalid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_dvalid", 64'(bus.dmem_req_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_strobes", {62'd0, retire, rf_we}, 64'd0);
        m_pc = '0;
        m_cnt_ret = 0;
        m_cnt_stall = 0;
        chk_counters();
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("rel_ivalid", 64'(bus.imem_req_valid), 64'd1);
        chk("rel_addr", bus.imem_addr, 64'd0);
        chk("rel_dvalid", 64'(bus.dmem_req_valid), 64'd0);
        chk("rel_err", 64'(err), 64'd0);
        quiet_bus();
    endtask

    // One instruction, lockstep with the expected state walk. Starts and
    // ends at a negedge where a fetch request should be up.
    task automatic run_instr(input logic [31:0] iw, input int dri, input int dwi,
                             input int drd, input int dwd, input bit abort_mem);
        int          cls;
        bit          is_mem, exp_we, exp_rf;
        logic [63:0] exp_next;
        logic [63:0] pc0;
        cls      = int'(iw[31:29]);
        is_mem   = (cls == C_LDUR) || (cls == C_STUR) || (cls == C_BOTH);
        exp_we   = (cls == C_STUR) || (cls == C_BOTH);
        exp_rf   = (cls == C_ALU) || (cls == C_LDUR);
        pc0      = m_pc;
        exp_next = model_next_pc(m_pc, iw);

        chk("fetch_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        chk("pc", pc, m_pc);
        for (int k = 0; k < dri; k++) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'($urandom);
            @(negedge clk);
            chk("fetch_hold", {31'd0, bus.imem_req_valid, bus.imem_addr[31:0]}, {31'd0, 1'b1, m_pc[31:0]});
        end
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'($urandom);
        bus.imem_rsp_data  = $urandom;
        @(negedge clk);
        chk("fetch_drop", 64'(bus.imem_req_valid), 64'd0);
        for (int k = 0; k < dwi; k++) begin
            bus.imem_req_ready = 1'($urandom);
            bus.imem_rsp_valid = 1'b0;
            @(negedge clk);
        end
        bus.imem_req_ready = 1'($urandom);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = iw;
        @(negedge clk);
        chk("ir", 64'(instr), 64'(iw));
        // DECODE and EXECUTE: everything arriving now must be ignored.
        for (int k = 0; k < 2; k++) begin
            bus.imem_req_ready = 1'($urandom);
            bus.imem_rsp_valid = 1'($urandom);
            bus.imem_rsp_data  = $urandom;
            bus.dmem_req_ready = 1'($urandom);
            bus.dmem_rsp_valid = 1'($urandom);
            @(negedge clk);
        end
        quiet_bus();
        if (is_mem) begin
            chk("dmem_valid", 64'(bus.dmem_req_valid), 64'd1);
            chk("dmem_we", 64'(bus.dmem_we), 64'(exp_we));
            for (int k = 0; k < drd; k++) begin
                bus.dmem_req_ready = 1'b0;
                bus.dmem_rsp_valid = 1'($urandom);
                @(negedge clk);
                chk("dmem_hold", {62'd0, bus.dmem_req_valid, bus.dmem_we}, {62'd0, 1'b1, exp_we});
            end
            bus.dmem_req_ready = 1'b1;
            bus.dmem_rsp_valid = 1'($urandom);
            @(negedge clk);
            chk("dmem_drop", 64'(bus.dmem_req_valid), 64'd0);
            bus.dmem_req_ready = 1'b0;
            bus.dmem_rsp_valid = 1'b0;
            if (abort_mem) begin
                $display("txn abort iw=%h pc=%h in mem wait", iw, pc0);
                return;
            end
            for (int k = 0; k < dwd; k++) begin
                bus.dmem_req_ready = 1'($urandom);
                bus.dmem_rsp_valid = 1'b0;
                @(negedge clk);
            end
            bus.dmem_req_ready = 1'($urandom);
            bus.dmem_rsp_valid = 1'b1;
            @(negedge clk);
            quiet_bus();
        end else begin
            chk("dmem_idle", 64'(bus.dmem_req_valid), 64'd0);
        end
        // WRITEBACK
        chk("retire", 64'(retire), 64'd1);
        chk("rf_we", 64'(rf_we), 64'(exp_rf));
        chk("pc_hold", pc, m_pc);
        chk("ir_hold", 64'(instr), 64'(iw));
        @(negedge clk);
        m_pc = exp_next;
        m_cnt_ret++;
        m_cnt_stall += longint'(dri + 1 + dwi + 1);
        if (is_mem) m_cnt_stall += longint'(drd + 1 + dwd + 1);
        model_retired_all++;
        chk("pc_next", pc, m_pc);
        chk("retire_off", {62'd0, retire, rf_we}, 64'd0);
        chk("err_clear", 64'(err), 64'd0);
        chk_counters();
        $display("txn cls=%0d iw=%h pc=%h->%h dly=%0d/%0d/%0d/%0d", cls, iw, pc0, m_pc, dri, dwi, drd, dwd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet_bus();
        m_pc = '0;
        m_cnt_ret = 0;
        m_cnt_stall = 0;
        do_reset();

        // ADD with zero-wait memory: pc 0 -> 4
        run_instr(mk(C_ALU, 0, 0), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_instr(mk(C_ALU, 0, 0), 0, 0, 0, 0, 0);
        // CBZ imm=-2 taken at 0x10 -> 0x08
        run_instr(mk(C_CBZ, 1, -2), 0, 0, 0, 0, 0);
        chk("cbz_taken_pc", m_pc, 64'h08);
        run_instr(mk(C_ALU, 0, 0), 1, 0, 0, 0, 0);
        run_instr(mk(C_NOP, 0, 0), 0, 1, 0, 0, 0);
        // CBZ not taken at 0x10 -> 0x14
        run_instr(mk(C_CBZ, 0, -2), 0, 0, 0, 0, 0);
        chk("cbz_fall_pc", pc, 64'h14);
        // LDUR: dmem ready low 3 cycles, response on second wait cycle
        run_instr(mk(C_LDUR, 0, 0), 0, 0, 3, 1, 0);
        run_instr(mk(C_STUR, 0, 0), 0, 0, 0, 0, 0);
        run_instr(mk(C_BOTH, 0, 0), 0, 0, 1, 0, 0);

        // B imm=5 from 0 -> 0x14, back to 0, then wrap below zero and forward
        do_reset();
        run_instr(mk(C_B, 0, 5), 0, 0, 0, 0, 0);
        chk("b_fwd_pc", pc, 64'h14);
        run_instr(mk(C_B, 0, -5), 0, 0, 0, 0, 0);
        run_instr(mk(C_B, 1, -1), 0, 0, 0, 0, 0);
        chk("b_wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(mk(C_ALU, 0, 0), 0, 0, 0, 0, 0);

        // Exactly TIMEOUT cycles in every wait state is still legal
        run_instr(mk(C_LDUR, 0, 0), T - 1, T - 1, T - 1, T - 1, 0);

        // Reset while waiting on a load response
        run_instr(mk(C_LDUR, 0, 0), 0, 0, 1, 0, 1);
        do_reset();

        // Randomized stream
        for (int n = 0; n < 40; n++) begin
            int cls;
            cls = int'($urandom_range(0, 6));
            run_instr(mk(cls, 1'($urandom), int'($urandom_range(0, 16)) - 8),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end
        chk("retire_pulses", 64'(retire_seen), 64'(model_retired_all));

        // Fetch timeout: ready held low
        do_reset();
        for (int k = 0; k < T - 1; k++) begin
            @(negedge clk);
            chk("to_pending", {62'd0, err, bus.imem_req_valid}, {62'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        chk("to_err", 64'(err), 64'd1);
        chk("to_strobes", {60'd0, bus.imem_req_valid, bus.dmem_req_valid, retire, rf_we}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'($urandom);
            bus.dmem_rsp_valid = 1'($urandom);
            @(negedge clk);
            chk("to_sticky", {61'd0, err, bus.imem_req_valid, retire}, {61'd0, 1'b1, 1'b0, 1'b0});
        end
        do_reset();
        run_instr(mk(C_ALU, 0, 0), 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
